// File: rtl/pps_sync_ctrl.sv
// PPS discipline controller: qualifies an external PPS against a nominal period,
// sequences freerun/acquire/lock/holdover and drives a disciplined local PPS.
module pps_sync_ctrl #(
  parameter int unsigned CLK_HZ     = 200_000_000,
  parameter int unsigned TOL        = 2000,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned PULSE_CYC  = 20_000_000,
  parameter int unsigned HOLD_MAX   = 60
) (
  input  logic        sys0_clk,
  input  logic        sys0_rst,
  input  logic        ext_en,
  input  logic        ppsExtIn,
  output logic        ppsOut,
  output logic        pps_tick,
  output logic [1:0]  state,
  output logic        locked,
  output logic [31:0] period,
  output logic [7:0]  lost_cnt
);

  typedef enum logic [1:0] {
    FREERUN  = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  localparam logic [31:0] WIN_LO  = 32'(CLK_HZ - TOL);
  localparam logic [31:0] WIN_HI  = 32'(CLK_HZ + TOL);
  localparam logic [31:0] TIMEOUT = 32'(CLK_HZ + TOL + 1);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MAX - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          ext_edge;
  logic [31:0]   cnt;
  logic [31:0]   lcnt;
  state_t        st;
  logic [GW-1:0] good;
  logic [HW-1:0] hold;
  logic [PW-1:0] pcnt;

  logic in_window;
  logic timeout;
  logic wrap;
  logic force_tick;
  logic tick;

  assign state = st;

  // Input path: two synchronizer flops, then a registered, gated rising-edge strobe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      ext_edge  <= 1'b0;
    end else begin
      sync1     <= ppsExtIn;
      sync2     <= sync1;
      sync_prev <= sync2;
      ext_edge  <= sync2 & ~sync_prev & ext_en;
    end
  end

  // cnt holds the distance since the last edge at the moment the next edge is seen.
  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      cnt <= 32'd0;
    end else if (ext_edge) begin
      cnt <= 32'd1;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign in_window  = ext_edge && (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign timeout    = !ext_edge && (cnt == TIMEOUT);
  assign wrap       = (lcnt >= period - 32'd1);
  assign force_tick = in_window &&
                      ((st == LOCKED) || ((st == ACQUIRE) && (good == GOOD_LAST)));
  // A forced realign and a natural wrap landing together collapse into one tick.
  assign tick       = force_tick || wrap;

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      lcnt <= 32'd0;
    end else if (tick) begin
      lcnt <= 32'd0;
    end else begin
      lcnt <= lcnt + 32'd1;
    end
  end

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      st       <= FREERUN;
      locked   <= 1'b0;
      good     <= '0;
      hold     <= '0;
      period   <= 32'(CLK_HZ);
      lost_cnt <= 8'd0;
    end else begin
      case (st)
        FREERUN: begin
          if (ext_edge) begin
            st   <= ACQUIRE;
            good <= '0;
          end
        end

        ACQUIRE: begin
          if (in_window) begin
            period <= cnt;
            good   <= good + GW'(1);
            if (good == GOOD_LAST) begin
              st     <= LOCKED;
              locked <= 1'b1;
            end
          end else if (ext_edge) begin
            good <= '0;
          end else if (timeout) begin
            st <= FREERUN;
          end
        end

        LOCKED: begin
          if (in_window) begin
            period <= cnt;
          end else if (ext_edge) begin
            st     <= ACQUIRE;
            locked <= 1'b0;
            good   <= '0;
          end else if (timeout) begin
            st     <= HOLDOVER;
            locked <= 1'b0;
            hold   <= '0;
            if (lost_cnt != 8'hFF) begin
              lost_cnt <= lost_cnt + 8'd1;
            end
          end
        end

        HOLDOVER: begin
          if (ext_edge) begin
            st   <= ACQUIRE;
            good <= '0;
          end else if (wrap) begin
            hold <= hold + HW'(1);
            if (hold == HOLD_LAST) begin
              st <= FREERUN;
            end
          end
        end

        default: begin
          st     <= FREERUN;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Output pulse: a new tick always restarts the high time from the full width.
  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      pps_tick <= 1'b0;
      ppsOut   <= 1'b0;
      pcnt     <= '0;
    end else begin
      pps_tick <= tick;
      if (tick) begin
        ppsOut <= 1'b1;
        pcnt   <= PULSE_LOAD;
      end else if (pcnt != '0) begin
        pcnt <= pcnt - PW'(1);
      end else begin
        ppsOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pps_sync_ctrl.sv
// Directed bench for pps_sync_ctrl with CLK_HZ=1000, TOL=10, LOCK_COUNT=3,
// PULSE_CYC=4, HOLD_MAX=2; outputs are sampled on the falling clock edge.
module tb_pps_sync_ctrl;

  logic        sys0_clk;
  logic        sys0_rst;
  logic        ext_en;
  logic        ppsExtIn;
  logic        ppsOut;
  logic        pps_tick;
  logic [1:0]  state;
  logic        locked;
  logic [31:0] period;
  logic [7:0]  lost_cnt;

  int checks = 0;
  int errors = 0;

  pps_sync_ctrl #(
    .CLK_HZ    (1000),
    .TOL       (10),
    .LOCK_COUNT(3),
    .PULSE_CYC (4),
    .HOLD_MAX  (2)
  ) dut (
    .sys0_clk (sys0_clk),
    .sys0_rst (sys0_rst),
    .ext_en   (ext_en),
    .ppsExtIn (ppsExtIn),
    .ppsOut   (ppsOut),
    .pps_tick (pps_tick),
    .state    (state),
    .locked   (locked),
    .period   (period),
    .lost_cnt (lost_cnt)
  );

  initial sys0_clk = 1'b0;
  always #5 sys0_clk = ~sys0_clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys0_clk);
  endtask

  // Raised at a falling edge N: sampled at the next rising edge k, effects visible at N+4.
  task automatic pulse_edge();
    ppsExtIn = 1'b1;
    wait_cyc(2);
    ppsExtIn = 1'b0;
  endtask

  task automatic do_reset();
    ppsExtIn = 1'b0;
    sys0_rst = 1'b1;
    wait_cyc(2);
    sys0_rst = 1'b0;
  endtask

  // Reset, then four edges spaced 1005 cycles; returns 2 cycles after the 4th edge was raised.
  task automatic lock_up();
    do_reset();
    wait_cyc(10);
    repeat (3) begin
      pulse_edge();
      wait_cyc(1003);
    end
    pulse_edge();
  endtask

  task automatic test_reset();
    wait_cyc(2);
    checks++; if (ppsOut !== 1'b0) begin errors++; $display("FAIL rst_ppsOut: got %0b want 0", ppsOut); end
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %0b want 0", pps_tick); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b want 0", locked); end
    checks++; if (period !== 32'd1000) begin errors++; $display("FAIL rst_period: got %0d want 1000", period); end
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL rst_lost: got %0d want 0", lost_cnt); end
    sys0_rst = 1'b0;
  endtask

  task automatic test_freerun();
    wait_cyc(999);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL fr_tick_early: got %0b want 0", pps_tick); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL fr_tick_1000: got %0b want 1", pps_tick); end
    checks++; if (ppsOut !== 1'b1) begin errors++; $display("FAIL fr_out_rise: got %0b want 1", ppsOut); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL fr_state: got %0d want 0", state); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL fr_tick_width: got %0b want 0", pps_tick); end
    wait_cyc(2);
    checks++; if (ppsOut !== 1'b1) begin errors++; $display("FAIL fr_out_last: got %0b want 1", ppsOut); end
    wait_cyc(1);
    checks++; if (ppsOut !== 1'b0) begin errors++; $display("FAIL fr_out_fall: got %0b want 0", ppsOut); end
    wait_cyc(995);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL fr_tick2_early: got %0b want 0", pps_tick); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL fr_tick_2000: got %0b want 1", pps_tick); end
  endtask

  task automatic test_acquire_lock();
    do_reset();
    wait_cyc(10);
    pulse_edge(); wait_cyc(1003);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL acq_state_e1: got %0d want 1", state); end
    pulse_edge(); wait_cyc(1003);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL acq_state_e2: got %0d want 1", state); end
    checks++; if (period !== 32'd1005) begin errors++; $display("FAIL acq_period_e2: got %0d want 1005", period); end
    pulse_edge(); wait_cyc(1003);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_locked_e3: got %0b want 0", locked); end
    pulse_edge(); wait_cyc(1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_locked_k2: got %0b want 0", locked); end
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL acq_tick_k2: got %0b want 0", pps_tick); end
    checks++; if (ppsOut !== 1'b0) begin errors++; $display("FAIL acq_out_k2: got %0b want 0", ppsOut); end
    wait_cyc(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acq_locked_k3: got %0b want 1", locked); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL acq_state_k3: got %0d want 2", state); end
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL acq_tick_k3: got %0b want 1", pps_tick); end
    checks++; if (ppsOut !== 1'b1) begin errors++; $display("FAIL acq_out_k3: got %0b want 1", ppsOut); end
    wait_cyc(1001);
    pulse_edge(); wait_cyc(1);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL trk_tick_k2: got %0b want 0", pps_tick); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL trk_tick_k3: got %0b want 1", pps_tick); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL trk_single_tick: got %0b want 0", pps_tick); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL trk_state: got %0d want 2", state); end
  endtask

  task automatic test_window_reject();
    lock_up();
    wait_cyc(978);
    pulse_edge(); wait_cyc(2);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rej_state: got %0d want 1", state); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rej_locked: got %0b want 0", locked); end
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL rej_no_tick: got %0b want 0", pps_tick); end
    checks++; if (period !== 32'd1005) begin errors++; $display("FAIL rej_period: got %0d want 1005", period); end
    wait_cyc(1001);
    pulse_edge(); wait_cyc(1003);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL relock_a: got %0d want 1", state); end
    pulse_edge(); wait_cyc(1003);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL relock_b: got %0d want 1", state); end
    pulse_edge(); wait_cyc(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL relock_c_k2: got %0d want 1", state); end
    wait_cyc(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL relock_c_k3: got %0d want 2", state); end
  endtask

  task automatic test_holdover();
    lock_up();
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL ho_lost_pre: got %0d want 0", lost_cnt); end
    wait_cyc(1012);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL ho_still_locked: got %0d want 2", state); end
    wait_cyc(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ho_enter: got %0d want 3", state); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ho_locked: got %0b want 0", locked); end
    checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL ho_lost: got %0d want 1", lost_cnt); end
    wait_cyc(998);
    checks++; if (pps_tick !== 1'b0) begin errors++; $display("FAIL ho_tick1_early: got %0b want 0", pps_tick); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL ho_tick1: got %0b want 1", pps_tick); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ho_state_t1: got %0d want 3", state); end
    wait_cyc(1004);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL ho_state_pre_t2: got %0d want 3", state); end
    wait_cyc(1);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL ho_tick2: got %0b want 1", pps_tick); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ho_to_freerun: got %0d want 0", state); end
    checks++; if (period !== 32'd1005) begin errors++; $display("FAIL ho_period_kept: got %0d want 1005", period); end
    wait_cyc(1005);
    checks++; if (pps_tick !== 1'b1) begin errors++; $display("FAIL fr_after_ho_tick: got %0b want 1", pps_tick); end
  endtask

  task automatic test_ext_en_gating();
    do_reset();
    ext_en = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < 4; i++) begin
      pulse_edge(); wait_cyc(1003);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL gate_state_%0d: got %0d want 0", i, state); end
    end
    checks++; if (period !== 32'd1000) begin errors++; $display("FAIL gate_period: got %0d want 1000", period); end
    ext_en = 1'b1;
    pulse_edge(); wait_cyc(2);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL gate_reenable: got %0d want 1", state); end
  endtask

  task automatic test_reset_mid();
    lock_up();
    wait_cyc(2);
    checks++; if (ppsOut !== 1'b1) begin errors++; $display("FAIL mid_pre_out: got %0b want 1", ppsOut); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL mid_pre_state: got %0d want 2", state); end
    sys0_rst = 1'b1;
    #1;
    checks++; if (ppsOut !== 1'b0) begin errors++; $display("FAIL mid_out: got %0b want 0", ppsOut); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %0b want 0", locked); end
    checks++; if (period !== 32'd1000) begin errors++; $display("FAIL mid_period: got %0d want 1000", period); end
    wait_cyc(2);
    sys0_rst = 1'b0;
  endtask

  task automatic test_boundary();
    do_reset();
    wait_cyc(10);
    pulse_edge(); wait_cyc(988);
    pulse_edge(); wait_cyc(2);
    checks++; if (period !== 32'd990) begin errors++; $display("FAIL bnd_990: got %0d want 990", period); end
    wait_cyc(1006);
    pulse_edge(); wait_cyc(2);
    checks++; if (period !== 32'd1010) begin errors++; $display("FAIL bnd_1010: got %0d want 1010", period); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bnd_1010_state: got %0d want 1", state); end
    wait_cyc(985);
    pulse_edge(); wait_cyc(2);
    checks++; if (period !== 32'd1010) begin errors++; $display("FAIL bnd_989: got %0d want 1010", period); end
    wait_cyc(1007);
    pulse_edge(); wait_cyc(2);
    checks++; if (period !== 32'd1010) begin errors++; $display("FAIL bnd_1011: got %0d want 1010", period); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bnd_edge_beats_timeout: got %0d want 1", state); end
    wait_cyc(1008);
    pulse_edge(); wait_cyc(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL bnd_timeout: got %0d want 0", state); end
    wait_cyc(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bnd_reacquire: got %0d want 1", state); end
  endtask

  initial begin
    sys0_rst = 1'b1;
    ext_en   = 1'b1;
    ppsExtIn = 1'b0;
    test_reset();
    test_freerun();
    test_acquire_lock();
    test_window_reject();
    test_holdover();
    test_ext_en_gating();
    test_reset_mid();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
